// File: rtl/alu_operand_deserializer_pkg.sv
// rtl/alu_operand_deserializer_pkg.sv - shared ALU opcode type and frame geometry
//
// Purpose : alu_op_t encoding, chosen so each enum value equals the frame opcode
//           field, plus the frame/field widths used by the deserializer.
// Ports   : none (package).
package alu_operand_deserializer_pkg;

  localparam int unsigned FRAME_BITS = 20;
  localparam int unsigned OPC_BITS   = 4;
  localparam int unsigned OPND_BITS  = 8;

  localparam logic [OPC_BITS-1:0] OPC_MAX_LEGAL = 4'd11;

  typedef enum logic [OPC_BITS-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_LUI   = 4'd2,
    ALU_SLL   = 4'd3,
    ALU_SRL   = 4'd4,
    ALU_SRA   = 4'd5,
    ALU_AUIPC = 4'd6,
    ALU_SLT   = 4'd7,
    ALU_SLTU  = 4'd8,
    ALU_XOR   = 4'd9,
    ALU_OR    = 4'd10,
    ALU_AND   = 4'd11
  } alu_op_t;

endpackage

// File: rtl/alu_operand_deserializer_ser_shift_reg.sv
// rtl/alu_operand_deserializer_ser_shift_reg.sv - serial-in/parallel-out shift register
//
// Purpose : WIDTH-bit shift register, new bits enter at bit 0 so the earliest
//           bit ends up most significant.
// Ports   : clock, reset (async, active-high)
//           clear    - synchronous clear; with shift_en it restarts at din
//           shift_en - shift din in this cycle
//           din      - serial input bit
//           q        - parallel contents
module ser_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (shift_en) begin
      // clear+shift together means "first bit of a new word"
      q <= clear ? WIDTH'(din) : {q[WIDTH-2:0], din};
    end else if (clear) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/alu_operand_deserializer.sv
// rtl/alu_operand_deserializer.sv - bit-serial frame receiver feeding the ALU
//
// Purpose : shifts in a 20-bit frame MSB first ({opcode, input1, input2}),
//           decodes the opcode and presents the operand set to the ALU behind
//           a valid/ready handshake. Illegal opcodes and restarts mid-frame
//           produce a one-cycle frame_err pulse.
// Ports   : clock, reset (async, active-high)
//           ser_valid/ser_data/ser_start/ser_ready - serial input side
//           op_valid/op_ready                      - operand handshake
//           alu_op, alu_input1, alu_input2         - held operand set
//           frame_err                              - malformed frame pulse
module alu_operand_deserializer
  import alu_operand_deserializer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ser_valid,
  input  logic                 ser_data,
  input  logic                 ser_start,
  output logic                 ser_ready,
  output logic                 op_valid,
  input  logic                 op_ready,
  output alu_op_t              alu_op,
  output logic [OPND_BITS-1:0] alu_input1,
  output logic [OPND_BITS-1:0] alu_input2,
  output logic                 frame_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } state_t;

  localparam logic [4:0] LAST_COUNT = 5'(FRAME_BITS - 1);

  state_t                  state;
  logic [4:0]              count;
  logic [FRAME_BITS-2:0]   sr_q;
  logic                    accept;
  logic                    sr_clear;
  logic                    sr_shift;
  logic [FRAME_BITS-1:0]   frame;
  logic [OPC_BITS-1:0]     opc;

  assign ser_ready = (state != S_HOLD);
  assign accept    = ser_valid && ser_ready;
  assign sr_clear  = accept && ser_start;
  assign sr_shift  = accept && (ser_start || (state == S_SHIFT));

  // Only the first 19 bits are stored; the final bit is taken straight from
  // ser_data so the outputs can load in the same cycle it is accepted.
  assign frame = {sr_q, ser_data};
  assign opc   = frame[FRAME_BITS-1 -: OPC_BITS];

  ser_shift_reg #(
    .WIDTH(FRAME_BITS - 1)
  ) u_shift (
    .clock    (clock),
    .reset    (reset),
    .clear    (sr_clear),
    .shift_en (sr_shift),
    .din      (ser_data),
    .q        (sr_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      op_valid   <= 1'b0;
      frame_err  <= 1'b0;
      alu_op     <= ALU_ADD;
      alu_input1 <= '0;
      alu_input2 <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && ser_start) begin
            count <= 5'd1;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (accept) begin
            if (ser_start) begin
              // restart: the partial frame is dropped, this bit is bit 19
              frame_err <= 1'b1;
              count     <= 5'd1;
            end else if (count == LAST_COUNT) begin
              count <= '0;
              if (opc <= OPC_MAX_LEGAL) begin
                alu_op     <= alu_op_t'(opc);
                alu_input1 <= frame[2*OPND_BITS-1 -: OPND_BITS];
                alu_input2 <= frame[OPND_BITS-1:0];
                op_valid   <= 1'b1;
                state      <= S_HOLD;
              end else begin
                frame_err <= 1'b1;
                state     <= S_IDLE;
              end
            end else begin
              count <= count + 5'd1;
            end
          end
        end
        S_HOLD: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_deserializer.sv
// tb/tb_alu_operand_deserializer.sv - self-checking bench for alu_operand_deserializer
module tb_alu_operand_deserializer;
  import alu_operand_deserializer_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ser_valid = 1'b0;
  logic       ser_data = 1'b0;
  logic       ser_start = 1'b0;
  logic       op_ready = 1'b0;
  logic       ser_ready;
  logic       op_valid;
  logic       frame_err;
  alu_op_t    alu_op;
  logic [7:0] alu_input1;
  logic [7:0] alu_input2;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  alu_operand_deserializer dut (
    .clock      (clock),
    .reset      (reset),
    .ser_valid  (ser_valid),
    .ser_data   (ser_data),
    .ser_start  (ser_start),
    .ser_ready  (ser_ready),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .alu_op     (alu_op),
    .alu_input1 (alu_input1),
    .alu_input2 (alu_input2),
    .frame_err  (frame_err)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: accumulates the frame as an integer and decides the
  // outcome once 20 accepted bits are collected.
  localparam int M_IDLE = 0, M_SHIFT = 1, M_HOLD = 2;
  int m_state = M_IDLE;
  int m_cnt = 0;
  int m_frame = 0;
  bit m_valid = 0;
  bit m_err = 0;
  int m_op = 0;
  int m_in1 = 0;
  int m_in2 = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_state = M_IDLE; m_cnt = 0; m_frame = 0; m_valid = 0; m_err = 0;
      m_op = 0; m_in1 = 0; m_in2 = 0;
    end else begin
      m_err = 0;
      if (m_state == M_HOLD) begin
        if (op_ready) begin
          m_state = M_IDLE;
          m_valid = 0;
        end
      end else if (ser_valid) begin
        if (ser_start) begin
          if (m_state == M_SHIFT) m_err = 1;
          m_frame = int'(ser_data);
          m_cnt = 1;
          m_state = M_SHIFT;
        end else if (m_state == M_SHIFT) begin
          m_frame = m_frame * 2 + int'(ser_data);
          m_cnt++;
          if (m_cnt == 20) begin
            if (m_frame / 65536 <= 11) begin
              m_op = m_frame / 65536;
              m_in1 = (m_frame / 256) % 256;
              m_in2 = m_frame % 256;
              m_valid = 1;
              m_state = M_HOLD;
            end else begin
              m_err = 1;
              m_state = M_IDLE;
            end
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("op_valid", op_valid, m_valid);
      chk("ser_ready", ser_ready, (m_state != M_HOLD));
      chk("frame_err", frame_err, m_err);
      chk("alu_op", alu_op, m_op);
      chk("alu_input1", alu_input1, m_in1);
      chk("alu_input2", alu_input2, m_in2);
    end
  end

  task automatic cyc(input logic v, input logic d, input logic s);
    ser_valid = v;
    ser_data = d;
    ser_start = s;
    @(posedge clock);
    #2;
  endtask

  task automatic send_bits(input logic [19:0] f, input int hi, input int lo, input bit gap);
    for (int i = hi; i >= lo; i--) begin
      if (gap) cyc(1'b0, 1'($urandom % 2), 1'($urandom % 2));
      cyc(1'b1, f[i], (i == 19));
    end
  endtask

  logic [19:0] f;

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_ser_ready", ser_ready, 1);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_in1", alu_input1, 0);
    chk("rst_in2", alu_input2, 0);
    @(posedge clock); #2;
    reset = 1'b0;
    cmp_en = 1'b1;

    // contiguous ADD frame
    op_ready = 1'b1;
    f = {4'd0, 8'h12, 8'h34};
    send_bits(f, 19, 1, 0);
    chk("t1_not_yet", op_valid, 0);
    send_bits(f, 0, 0, 0);
    chk("t1_valid", op_valid, 1);
    chk("t1_op", alu_op, ALU_ADD);
    chk("t1_in1", alu_input1, 8'h12);
    chk("t1_in2", alu_input2, 8'h34);
    chk("model_t1_in1", m_in1, 8'h12);
    chk("model_t1_in2", m_in2, 8'h34);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t1_released", op_valid, 0);

    // SRA frame with ser_valid every other cycle
    f = {4'd5, 8'hA5, 8'h0F};
    send_bits(f, 19, 0, 1);
    chk("t2_valid", op_valid, 1);
    chk("t2_op", alu_op, ALU_SRA);
    chk("t2_in1", alu_input1, 8'hA5);
    chk("model_t2_op", m_op, 5);
    cyc(1'b0, 1'b0, 1'b0);

    // backpressure with serial noise
    op_ready = 1'b0;
    f = {4'd9, 8'h3C, 8'hC3};
    send_bits(f, 19, 0, 0);
    for (int k = 0; k < 10; k++) begin
      chk("t3_hold_valid", op_valid, 1);
      chk("t3_hold_ready", ser_ready, 0);
      chk("t3_hold_op", alu_op, ALU_XOR);
      chk("t3_hold_in1", alu_input1, 8'h3C);
      chk("t3_hold_in2", alu_input2, 8'hC3);
      cyc(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
    end
    op_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("t3_released", op_valid, 0);
    chk("t3_ready_back", ser_ready, 1);

    // illegal opcode 0xE
    f = {4'hE, 8'h55, 8'hAA};
    send_bits(f, 19, 0, 0);
    chk("t4_err", frame_err, 1);
    chk("t4_no_valid", op_valid, 0);
    chk("t4_keep_op", alu_op, ALU_XOR);
    chk("t4_keep_in2", alu_input2, 8'hC3);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t4_err_pulse", frame_err, 0);

    // restart after 7 bits
    f = {4'd3, 8'h77, 8'h11};
    send_bits(f, 19, 13, 0);
    f = {4'd1, 8'hFF, 8'h01};
    send_bits(f, 19, 19, 0);
    chk("t5_restart_err", frame_err, 1);
    send_bits(f, 18, 0, 0);
    chk("t5_valid", op_valid, 1);
    chk("t5_op", alu_op, ALU_SUB);
    chk("t5_in1", alu_input1, 8'hFF);
    chk("t5_in2", alu_input2, 8'h01);
    chk("t5_err_clear", frame_err, 0);
    cyc(1'b0, 1'b0, 1'b0);

    // async reset during bit 10
    f = {4'd2, 8'h12, 8'h34};
    send_bits(f, 19, 10, 0);
    #1 reset = 1'b1;
    #1;
    chk("t6_valid", op_valid, 0);
    chk("t6_ready", ser_ready, 1);
    chk("t6_err", frame_err, 0);
    chk("t6_op", alu_op, ALU_ADD);
    chk("t6_in1", alu_input1, 0);
    @(posedge clock); #2;
    reset = 1'b0;
    f = {4'd11, 8'hF0, 8'h3C};
    send_bits(f, 19, 0, 0);
    chk("t6_new_valid", op_valid, 1);
    chk("t6_new_op", alu_op, ALU_AND);
    chk("t6_new_in1", alu_input1, 8'hF0);
    chk("t6_new_in2", alu_input2, 8'h3C);
    cyc(1'b0, 1'b0, 1'b0);

    // randomized frames, gaps, backpressure and noise
    for (int n = 0; n < 40; n++) begin
      op_ready = 1'($urandom % 2);
      f = 20'($urandom);
      send_bits(f, 19, 0, 1'($urandom % 2));
      for (int k = 0; k < 5; k++) begin
        op_ready = 1'($urandom % 2);
        cyc(1'($urandom % 4 != 0), 1'($urandom % 2), 1'($urandom % 16 == 0));
      end
    end
    op_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
